// File: rtl/err_meas_seq_pkg.sv
// Shared definitions for the error-measurement sequencer.
// Holds the error sample width and the FSM state encoding used by err_meas_seq.
package err_meas_seq_pkg;

  // Width of the error generator accumulator outputs and of the averaged results.
  localparam int unsigned ERR_W = 18;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArm    = 3'd1,
    StSettle = 3'd2,
    StMeas   = 3'd3,
    StDone   = 3'd4
  } state_e;

  // States in which the symbol watchdog runs.
  function automatic logic is_run_state(input state_e s);
    return (s == StArm) || (s == StSettle) || (s == StMeas);
  endfunction

endpackage

// File: rtl/err_avg_acc.sv
// Signed accumulate-and-shift unit: sums 2^LOG2_AVG error samples and latches their
// floor-average.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clr          : clear the running sum (start of a run)
//   i_acc          : add i_data to the running sum
//   i_load         : final sample; latch (sum + i_data) >>> LOG2_AVG into o_avg
//   i_data         : signed error sample
//   o_avg          : averaged result, held until the next load
module err_avg_acc
  import err_meas_seq_pkg::*;
#(
  parameter int unsigned LOG2_AVG = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_clr,
  input  logic                    i_acc,
  input  logic                    i_load,
  input  logic signed [ERR_W-1:0] i_data,
  output logic signed [ERR_W-1:0] o_avg
);

  // Widened so 2^LOG2_AVG full-scale samples cannot overflow.
  localparam int unsigned SUM_W = ERR_W + LOG2_AVG;

  logic signed [SUM_W-1:0] r_sum;
  logic signed [SUM_W-1:0] w_sum_nxt;
  logic signed [ERR_W-1:0] r_avg;

  always_comb begin
    w_sum_nxt = r_sum + {{LOG2_AVG{i_data[ERR_W-1]}}, i_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sum <= '0;
      r_avg <= '0;
    end else begin
      if (i_clr) begin
        r_sum <= '0;
      end else if (i_acc) begin
        r_sum <= w_sum_nxt;
      end
      // Dropping the low LOG2_AVG bits of a signed sum is an arithmetic shift (floor).
      if (i_load) begin
        r_avg <= w_sum_nxt[SUM_W-1:LOG2_AVG];
      end
    end
  end

  assign o_avg = r_avg;

endmodule

// File: rtl/err_meas_seq.sv
// Error-measurement run sequencer for the 16-QAM receiver path.
// Arms on start, aligns to the LFSR period boundary, skips SETTLE_PERIODS boundaries,
// then averages 2^LOG2_AVG captured DC and squared error samples and pulses done.
// Ports:
//   i_clk, i_reset           : clock, synchronous active-high reset
//   i_sym_en                 : symbol-rate clock enable
//   i_start, i_abort         : one-clk run request / cancel
//   i_cycle_out_periodic     : LFSR period boundary flag (qualified by i_sym_en)
//   i_acc_dc_err_in          : err_dc_gen accumulator output
//   i_acc_sq_err_in          : err_sq_gen accumulator output
//   o_acc_clr                : clear pulse to both error generators
//   o_busy, o_done           : run active / results updated pulse
//   o_timeout_err            : sticky boundary-timeout flag
//   o_dc_err_avg, o_sq_err_avg : averaged errors, held until next done
module err_meas_seq
  import err_meas_seq_pkg::*;
#(
  parameter int unsigned LOG2_AVG       = 2,
  parameter int unsigned SETTLE_PERIODS = 1,
  parameter int unsigned TIMEOUT_SYMS   = 65535
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_sym_en,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic                    i_cycle_out_periodic,
  input  logic signed [ERR_W-1:0] i_acc_dc_err_in,
  input  logic signed [ERR_W-1:0] i_acc_sq_err_in,
  output logic                    o_acc_clr,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_timeout_err,
  output logic signed [ERR_W-1:0] o_dc_err_avg,
  output logic signed [ERR_W-1:0] o_sq_err_avg
);

  localparam int unsigned SYM_CNT_W = $clog2(TIMEOUT_SYMS + 1);
  localparam logic [SYM_CNT_W-1:0] SYM_LAST = SYM_CNT_W'(TIMEOUT_SYMS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_PERIODS == 0) ? 0 : SETTLE_PERIODS - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [SYM_CNT_W-1:0]  r_sym_cnt;
  logic [3:0]            r_settle_cnt;
  logic [LOG2_AVG-1:0]   r_cap_cnt;
  logic                  r_cap_pend;
  logic                  r_timeout_err;

  logic w_bnd;
  logic w_cap;
  logic w_start_acc;
  logic w_abort;
  logic w_timeout;
  logic w_meas_acc;
  logic w_last_cap;

  always_comb begin
    w_bnd       = i_sym_en & i_cycle_out_periodic;
    // Generators register on the boundary, so the sample is valid on the next sym_en.
    w_cap       = i_sym_en & r_cap_pend;
    w_start_acc = (r_state == StIdle) & i_start;
    w_abort     = (r_state != StIdle) & i_abort;
    w_timeout   = is_run_state(r_state) & i_sym_en & ~w_bnd & (r_sym_cnt == SYM_LAST);
    // Abort beats a coincident capture: the sample is dropped.
    w_meas_acc  = (r_state == StMeas) & w_cap & ~i_abort & ~w_timeout;
    w_last_cap  = w_meas_acc & (r_cap_cnt == '1);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (i_start) w_state_nxt = StArm;
      StArm:    if (w_bnd) w_state_nxt = (SETTLE_PERIODS == 0) ? StMeas : StSettle;
      StSettle: if (w_bnd && (r_settle_cnt == SETTLE_LAST)) w_state_nxt = StMeas;
      StMeas:   if (w_last_cap) w_state_nxt = StDone;
      StDone:   w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
    if (w_abort || w_timeout) begin
      w_state_nxt = StIdle;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_sym_cnt     <= '0;
      r_settle_cnt  <= '0;
      r_cap_cnt     <= '0;
      r_cap_pend    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // Watchdog: never exceeds SYM_LAST because the timeout leaves the run first.
      if (!is_run_state(w_state_nxt) || w_bnd) begin
        r_sym_cnt <= '0;
      end else if (i_sym_en) begin
        r_sym_cnt <= r_sym_cnt + 1'b1;
      end

      if (r_state != StSettle) begin
        r_settle_cnt <= '0;
      end else if (w_bnd) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end

      // Only boundaries seen while already in MEAS arm a capture.
      if ((r_state != StMeas) || (w_state_nxt != StMeas)) begin
        r_cap_pend <= 1'b0;
      end else if (i_sym_en) begin
        r_cap_pend <= w_bnd;
      end

      if (r_state != StMeas) begin
        r_cap_cnt <= '0;
      end else if (w_meas_acc) begin
        r_cap_cnt <= r_cap_cnt + 1'b1;
      end

      if (w_start_acc) begin
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  err_avg_acc #(
    .LOG2_AVG(LOG2_AVG)
  ) u_dc_acc (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clr  (w_start_acc),
    .i_acc  (w_meas_acc),
    .i_load (w_last_cap),
    .i_data (i_acc_dc_err_in),
    .o_avg  (o_dc_err_avg)
  );

  err_avg_acc #(
    .LOG2_AVG(LOG2_AVG)
  ) u_sq_acc (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clr  (w_start_acc),
    .i_acc  (w_meas_acc),
    .i_load (w_last_cap),
    .i_data (i_acc_sq_err_in),
    .o_avg  (o_sq_err_avg)
  );

  assign o_acc_clr     = w_start_acc & ~i_reset;
  assign o_busy        = (r_state != StIdle);
  assign o_done        = (r_state == StDone);
  assign o_timeout_err = r_timeout_err;

endmodule
